// File: rtl/traffic_pkg.sv
// Shared types for the two-road traffic-light controller.
// State encoding is fixed so display/debug logic can decode it directly.
package traffic_pkg;

    typedef enum logic [2:0] {
        S_G1    = 3'd0,
        S_Y1    = 3'd1,
        S_G2    = 3'd2,
        S_Y2    = 3'd3,
        S_NIGHT = 3'd4
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle strobe every DIV clock cycles.
// The strobe is high while the divider sits at its terminal count.
module tick_gen #(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic clk,
    input  logic rs,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] div_q;

    assign tick = (div_q == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rs) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light sequencer with pedestrian shortening, flashing-yellow
// night mode and per-road countdowns for the display block.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned T_G1     = 15,
    parameter int unsigned T_G2     = 15,
    parameter int unsigned T_Y      = 5,
    parameter int unsigned T_PED    = 5,
    parameter int unsigned CW       = 8
) (
    input  logic          clk,
    input  logic          rs,
    input  logic          night,
    input  logic          ped_req,
    output logic          X1,
    output logic          V1,
    output logic          D1,
    output logic          X2,
    output logic          V2,
    output logic          D2,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2,
    output logic          tick
);

    state_e        state_q;
    logic [CW-1:0] ph_q;
    logic          ped_pend_q;
    logic          blink_q;
    logic          ped_clr;
    logic [CW-1:0] ph_p1;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rs   (rs),
        .tick (tick)
    );

    // Any tick in S_G1 consumes a pending request, whether or not it shortens.
    assign ped_clr = tick && (state_q == S_G1) && ped_pend_q;

    always_ff @(posedge clk) begin
        if (!rs) begin
            state_q    <= S_G1;
            ph_q       <= CW'(T_G1 - 1);
            ped_pend_q <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            ped_pend_q <= ped_req | (ped_pend_q & ~ped_clr);
            if (tick) begin
                case (state_q)
                    S_G1: begin
                        if (ph_q == '0) begin
                            state_q <= S_Y1;
                            ph_q    <= CW'(T_Y - 1);
                        end else if (ped_pend_q && (ph_q > CW'(T_PED - 1))) begin
                            ph_q <= CW'(T_PED - 1);
                        end else begin
                            ph_q <= ph_q - 1'b1;
                        end
                    end
                    S_Y1, S_Y2: begin
                        if (ph_q != '0) begin
                            ph_q <= ph_q - 1'b1;
                        end else if (night) begin
                            state_q <= S_NIGHT;
                            blink_q <= 1'b1;
                        end else if (state_q == S_Y1) begin
                            state_q <= S_G2;
                            ph_q    <= CW'(T_G2 - 1);
                        end else begin
                            state_q <= S_G1;
                            ph_q    <= CW'(T_G1 - 1);
                        end
                    end
                    S_G2: begin
                        if (ph_q == '0) begin
                            state_q <= S_Y2;
                            ph_q    <= CW'(T_Y - 1);
                        end else begin
                            ph_q <= ph_q - 1'b1;
                        end
                    end
                    S_NIGHT: begin
                        if (!night) begin
                            state_q <= S_G1;
                            ph_q    <= CW'(T_G1 - 1);
                        end else begin
                            blink_q <= ~blink_q;
                        end
                    end
                    default: begin
                        state_q <= S_G1;
                        ph_q    <= CW'(T_G1 - 1);
                    end
                endcase
            end
        end
    end

    assign ph_p1 = ph_q + 1'b1;

    always_comb begin
        {X1, V1, D1, X2, V2, D2} = 6'b000000;
        cnt1 = '0;
        cnt2 = '0;
        case (state_q)
            S_G1: begin
                {X1, D2} = 2'b11;
                cnt1     = ph_p1;
                cnt2     = ph_p1 + CW'(T_Y);
            end
            S_Y1: begin
                {V1, D2} = 2'b11;
                cnt1     = ph_p1;
                cnt2     = ph_p1;
            end
            S_G2: begin
                {D1, X2} = 2'b11;
                cnt1     = ph_p1 + CW'(T_Y);
                cnt2     = ph_p1;
            end
            S_Y2: begin
                {D1, V2} = 2'b11;
                cnt1     = ph_p1;
                cnt2     = ph_p1;
            end
            S_NIGHT: begin
                V1 = blink_q;
                V2 = blink_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs, which are
// queued at drive time and compared after the DUT clock edge.
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned T_G1     = 3;
    localparam int unsigned T_G2     = 2;
    localparam int unsigned T_Y      = 1;
    localparam int unsigned T_PED    = 1;
    localparam int unsigned CW       = 8;

    typedef struct packed {
        logic [6:0]    lights;
        logic [CW-1:0] cnt1;
        logic [CW-1:0] cnt2;
        logic          night_st;
    } exp_t;

    logic          clk = 1'b0;
    logic          rs = 1'b0;
    logic          night = 1'b0;
    logic          ped_req = 1'b0;
    logic          X1, V1, D1, X2, V2, D2, tick;
    logic [CW-1:0] cnt1, cnt2;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    state_e m_state = S_G1;
    int     m_secs = T_G1;
    int     m_div = 0;
    logic   m_pend = 1'b0;
    logic   m_blink = 1'b0;

    traffic_light_ctrl #(
        .TICK_DIV (TICK_DIV),
        .T_G1     (T_G1),
        .T_G2     (T_G2),
        .T_Y      (T_Y),
        .T_PED    (T_PED),
        .CW       (CW)
    ) dut (
        .clk     (clk),
        .rs      (rs),
        .night   (night),
        .ped_req (ped_req),
        .X1      (X1),
        .V1      (V1),
        .D1      (D1),
        .X2      (X2),
        .V2      (V2),
        .D2      (D2),
        .cnt1    (cnt1),
        .cnt2    (cnt2),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model tracks whole seconds left in the phase rather than a phase index.
    task automatic model_step();
        logic t;
        logic clr;
        if (!rs) begin
            m_state = S_G1;
            m_secs  = T_G1;
            m_div   = 0;
            m_pend  = 1'b0;
            m_blink = 1'b0;
            return;
        end
        t     = (m_div == TICK_DIV - 1);
        m_div = t ? 0 : m_div + 1;
        clr   = t && (m_state == S_G1) && m_pend;
        if (t) begin
            case (m_state)
                S_G1: begin
                    if (m_secs == 1) begin
                        m_state = S_Y1;
                        m_secs  = T_Y;
                    end else if (m_pend && m_secs > T_PED) begin
                        m_secs = T_PED;
                    end else begin
                        m_secs--;
                    end
                end
                S_Y1: begin
                    if (m_secs > 1) m_secs--;
                    else if (night) begin
                        m_state = S_NIGHT;
                        m_blink = 1'b1;
                    end else begin
                        m_state = S_G2;
                        m_secs  = T_G2;
                    end
                end
                S_G2: begin
                    if (m_secs == 1) begin
                        m_state = S_Y2;
                        m_secs  = T_Y;
                    end else begin
                        m_secs--;
                    end
                end
                S_Y2: begin
                    if (m_secs > 1) m_secs--;
                    else if (night) begin
                        m_state = S_NIGHT;
                        m_blink = 1'b1;
                    end else begin
                        m_state = S_G1;
                        m_secs  = T_G1;
                    end
                end
                default: begin
                    if (!night) begin
                        m_state = S_G1;
                        m_secs  = T_G1;
                    end else begin
                        m_blink = !m_blink;
                    end
                end
            endcase
        end
        m_pend = ped_req | (m_pend & !clr);
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic t;
        t          = (m_div == TICK_DIV - 1);
        e.night_st = 1'b0;
        e.cnt1     = CW'(m_secs);
        e.cnt2     = CW'(m_secs);
        case (m_state)
            S_G1: begin
                e.lights = {6'b100001, t};
                e.cnt2   = CW'(m_secs + T_Y);
            end
            S_Y1: e.lights = {6'b010001, t};
            S_G2: begin
                e.lights = {6'b001100, t};
                e.cnt1   = CW'(m_secs + T_Y);
            end
            S_Y2: e.lights = {6'b001010, t};
            default: begin
                e.lights   = {1'b0, m_blink, 2'b00, m_blink, 1'b0, t};
                e.cnt1     = '0;
                e.cnt2     = '0;
                e.night_st = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic step();
        exp_t e;
        model_step();
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("lights", {X1, V1, D1, X2, V2, D2, tick}, e.lights);
            check("cnt1", cnt1, e.cnt1);
            check("cnt2", cnt2, e.cnt2);
            if (!e.night_st) begin
                check("onehot_road1", $countones({X1, V1, D1}), 1);
                check("onehot_road2", $countones({X2, V2, D2}), 1);
            end
            check("no_dual_green", X1 & X2, 0);
        end
    endtask

    initial begin
        int n;
        logic [7:0] seq [7];

        // Reset and free run for two full cycles; record cnt1 at each tick edge.
        rs = 1'b0;
        step();
        step();
        check("rst_cnt1", cnt1, 3);
        check("rst_cnt2", cnt2, 4);
        rs = 1'b1;
        n = 0;
        for (int i = 0; i < 56; i++) begin
            step();
            if (i % TICK_DIV == 0 && n < 7) begin
                seq[n] = cnt1;
                n++;
            end
        end
        check("cnt1_seq0", seq[0], 3);
        check("cnt1_seq1", seq[1], 2);
        check("cnt1_seq2", seq[2], 1);
        check("cnt1_seq3", seq[3], 1);
        check("cnt1_seq4", seq[4], 3);
        check("cnt1_seq5", seq[5], 2);
        check("cnt1_seq6", seq[6], 1);

        // Reset while in S_G2, then time the first tick after release.
        n = 0;
        while (m_state != S_G2 && n < 40) begin
            step();
            n++;
        end
        step();
        rs = 1'b0;
        step();
        rs = 1'b1;
        check("midrst_x1", X1, 1);
        check("midrst_d2", D2, 1);
        check("midrst_cnt1", cnt1, 3);
        check("midrst_cnt2", cnt2, 4);
        n = 0;
        while (cnt1 == 3 && n < 20) begin
            step();
            n++;
        end
        check("first_tick_edge", n, 4);

        // Pedestrian request in first cycle of S_G1 shortens it to two seconds.
        rs = 1'b0;
        step();
        rs = 1'b1;
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        n = 1;
        while (!V1 && n < 40) begin
            step();
            n++;
        end
        check("ped_y1_start", n, 8);
        for (int i = 0; i < 40; i++) step();

        // Night mode entered at end of S_Y1, then released.
        rs = 1'b0;
        step();
        rs = 1'b1;
        for (int i = 0; i < 3; i++) step();
        night = 1'b1;
        for (int i = 0; i < 40; i++) step();
        night = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Mixed traffic: sporadic requests and night toggles.
        for (int i = 0; i < 400; i++) begin
            ped_req = ($urandom_range(0, 15) == 0);
            if (i % 60 == 30) night = ~night;
            step();
        end
        ped_req = 1'b0;
        night = 1'b0;
        for (int i = 0; i < 20; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
